// File: rtl/column_window_pkg.sv
// Shared types and constants for the column window feeder.
// Holds size defaults, column index width and the row state type.
package column_window_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int IMG_WIDTH_DEF = 64;

    // Column index width for a given line length (at least 1 bit).
    function automatic int col_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    localparam int COL_W_DEF = col_w(IMG_WIDTH_DEF);

    typedef enum logic [1:0] {
        ROW0,
        ROW1,
        PRIMED
    } row_state_t;

    // Row state advance at end of line; saturates in PRIMED.
    function automatic row_state_t next_row(input row_state_t s);
        unique case (s)
            ROW0:    return ROW1;
            ROW1:    return PRIMED;
            default: return PRIMED;
        endcase
    endfunction

endpackage

// File: rtl/column_window_if.sv
// Pixel stream in, vertical 3-pixel column out.
// Slave side is the column window, master side the stream source/sink.
interface column_window_if
    import column_window_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IMG_WIDTH = IMG_WIDTH_DEF
);
    localparam int COL_W = col_w(IMG_WIDTH);

    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic [DATA_W-1:0] out_y1;
    logic [DATA_W-1:0] out_y0;
    logic [DATA_W-1:0] out_ym1;
    logic [COL_W-1:0]  out_col;

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output out_valid, out_y1, out_y0, out_ym1, out_col
    );

    modport master (
        output in_valid, in_sof, in_pixel,
        input  out_valid, out_y1, out_y0, out_ym1, out_col
    );
endinterface

// File: rtl/column_window_line_buffer.sv
// Single-port line memory, read-before-write, no reset.
// Read is combinational so old contents are seen in the write cycle.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Write the new pixel; old word is already on rd_data this cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end
endmodule

// File: rtl/column_window.sv
// Raster stream to vertical 3-pixel columns for the median filter.
// Two line buffers hold the previous two rows; outputs are registered.
module column_window
    import column_window_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IMG_WIDTH = IMG_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    column_window_if.slave  bus
);
    localparam int COL_W = col_w(IMG_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0]  col;
    row_state_t        state;
    logic [COL_W-1:0]  cur_col;
    row_state_t        cur_state;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    // Start of frame overrides the position for the pixel it marks.
    always_comb begin
        cur_col   = col;
        cur_state = state;
        if (bus.in_sof) begin
            cur_col   = '0;
            cur_state = ROW0;
        end
    end

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk     (clk),
        .we      (bus.in_valid),
        .addr    (cur_col),
        .wr_data (bus.in_pixel),
        .rd_data (lb0_rd)
    );

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .we      (bus.in_valid),
        .addr    (cur_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Position tracking and registered column output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col           <= '0;
            state         <= ROW0;
            bus.out_valid <= 1'b0;
            bus.out_y1    <= '0;
            bus.out_y0    <= '0;
            bus.out_ym1   <= '0;
            bus.out_col   <= '0;
        end else if (bus.in_valid) begin
            bus.out_valid <= (cur_state == PRIMED);
            bus.out_ym1   <= bus.in_pixel;
            bus.out_y0    <= lb0_rd;
            bus.out_y1    <= lb1_rd;
            bus.out_col   <= cur_col;
            if (cur_col == LAST_COL) begin
                col   <= '0;
                state <= next_row(cur_state);
            end else begin
                col   <= cur_col + COL_W'(1);
                state <= cur_state;
            end
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_column_window.sv
// Directed bench for column_window with IMG_WIDTH=4, DATA_W=8.
// Each task drives one scenario and checks outputs inline.
module tb_column_window;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    column_window_if #(.DATA_W(8), .IMG_WIDTH(4)) bus ();

    column_window #(
        .DATA_W    (8),
        .IMG_WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted pixel; returns 1 ns after the capturing edge.
    task automatic drive(input logic sof, input logic [7:0] pix);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic sof);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = sof;
        bus.in_pixel = 8'hA5;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.out_valid, bus.out_y1, bus.out_y0, bus.out_ym1, bus.out_col}
            !== 27'd0) begin
            fails++;
            $display("FAIL reset: got v=%0b y1=%0d y0=%0d ym1=%0d col=%0d want all 0",
                     bus.out_valid, bus.out_y1, bus.out_y0, bus.out_ym1, bus.out_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pixels 0..15 with sof; stall_at>=0 inserts a 3-cycle stall after it.
    task automatic run_frame(input string name, input int stall_at);
        for (int p = 0; p < 16; p++) begin
            drive(p == 0, 8'(p));
            tests++;
            if (bus.out_valid !== (p >= 8)) begin
                fails++;
                $display("FAIL %s valid p=%0d: got %0b want %0b",
                         name, p, bus.out_valid, p >= 8);
            end
            if (p >= 8) begin
                tests++;
                if (bus.out_y1 !== 8'(p - 8) || bus.out_y0 !== 8'(p - 4) ||
                    bus.out_ym1 !== 8'(p) || bus.out_col !== 2'(p % 4)) begin
                    fails++;
                    $display("FAIL %s data p=%0d: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                             name, p, bus.out_y1, bus.out_y0, bus.out_ym1,
                             bus.out_col, p - 8, p - 4, p, p % 4);
                end
            end
            if (p == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    idle(s == 1);
                    tests++;
                    if (bus.out_valid !== 1'b0 || bus.out_y1 !== 8'(p - 8) ||
                        bus.out_y0 !== 8'(p - 4) || bus.out_ym1 !== 8'(p) ||
                        bus.out_col !== 2'(p % 4)) begin
                        fails++;
                        $display("FAIL %s stall s=%0d: got v=%0b (%0d,%0d,%0d,%0d) want v=0 held",
                                 name, s, bus.out_valid, bus.out_y1, bus.out_y0,
                                 bus.out_ym1, bus.out_col);
                    end
                end
            end
        end
        idle(1'b0);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s drop: got valid %0b want 0", name, bus.out_valid);
        end
    endtask

    task automatic test_frame();
        run_frame("frame", -1);
    endtask

    task automatic test_stall();
        run_frame("stall", 9);
    endtask

    task automatic test_mid_sof();
        for (int p = 0; p < 6; p++) begin
            drive(p == 0, 8'(p));
        end
        for (int k = 0; k < 9; k++) begin
            drive(k == 0, 8'(6 + k));
            tests++;
            if (bus.out_valid !== (k == 8)) begin
                fails++;
                $display("FAIL midsof valid k=%0d: got %0b want %0b",
                         k, bus.out_valid, k == 8);
            end
        end
        tests++;
        if (bus.out_y1 !== 8'd6 || bus.out_y0 !== 8'd10 ||
            bus.out_ym1 !== 8'd14 || bus.out_col !== 2'd0) begin
            fails++;
            $display("FAIL midsof data: got (%0d,%0d,%0d,%0d) want (6,10,14,0)",
                     bus.out_y1, bus.out_y0, bus.out_ym1, bus.out_col);
        end
        idle(1'b0);
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < 10; p++) begin
            drive(p == 0, 8'(p));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, bus.out_y1, bus.out_y0, bus.out_ym1, bus.out_col}
            !== 27'd0) begin
            fails++;
            $display("FAIL async_reset: got v=%0b y1=%0d y0=%0d ym1=%0d col=%0d want all 0",
                     bus.out_valid, bus.out_y1, bus.out_y0, bus.out_ym1, bus.out_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset", -1);
    endtask

    task automatic test_wrap();
        int run;
        int nvalid;
        run    = 0;
        nvalid = 0;
        for (int p = 0; p < 20; p++) begin
            drive(p == 0, 8'hFF);
            tests++;
            if (bus.out_col !== 2'(p % 4)) begin
                fails++;
                $display("FAIL wrap col p=%0d: got %0d want %0d",
                         p, bus.out_col, p % 4);
            end
            if (bus.out_valid === 1'b1) begin
                nvalid++;
                run++;
                tests++;
                if (bus.out_y1 !== 8'hFF || bus.out_y0 !== 8'hFF ||
                    bus.out_ym1 !== 8'hFF) begin
                    fails++;
                    $display("FAIL wrap data p=%0d: got (%0h,%0h,%0h) want (ff,ff,ff)",
                             p, bus.out_y1, bus.out_y0, bus.out_ym1);
                end
            end else begin
                run = 0;
            end
        end
        tests++;
        if (nvalid != 12 || run != 12) begin
            fails++;
            $display("FAIL wrap count: got %0d valid, run %0d want 12, 12",
                     nvalid, run);
        end
        idle(1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_frame();
        test_stall();
        test_mid_sof();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/column_window.md
COLUMN_WINDOW -- requirements
Module: column_window

Interface
REQ-001 Parameter: DATA_W, 8, pixel width in bits.
REQ-002 Parameter: IMG_WIDTH, 64, pixels per line (≥2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  in_pixel valid this cycle.
REQ-006 Port: in_sof  input  1  start of frame; qualified by in_valid; marks pixel (row 0, col 0).
REQ-007 Port: in_pixel  input  DATA_W  raster-order pixel.
REQ-008 Port: out_valid  output  1  output column valid.
REQ-009 Port: out_y1  output  DATA_W  pixel two rows above the current row, same column.
REQ-010 Port: out_y0  output  DATA_W  pixel one row above the current row, same column.
REQ-011 Port: out_ym1  output  DATA_W  current-row pixel (newest).
REQ-012 Port: out_col  output  clog2(IMG_WIDTH)  column index of the output column.
REQ-013 Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-014 Block SHALL be the upstream feeder of the 3-pixel column median: it converts a raster stream into vertical 3-pixel columns.
REQ-015 Two line buffers, each IMG_WIDTH deep, SHALL hold the previous row (LB0) and the row before that (LB1).
REQ-016 On an accepted pixel at column c: read LB0[c] and LB1[c]; write in_pixel to LB0[c]; write the old LB0[c] to LB1[c] (read-before-write).
REQ-017 Outputs SHALL be registered, with latency exactly 1 cycle from the accepting in_valid edge: out_ym1=in_pixel, out_y0=old LB0[c], out_y1=old LB1[c], out_col=c.
REQ-018 Column counter SHALL increment per accepted pixel and wrap IMG_WIDTH-1 → 0.
REQ-019 On wrap, row state SHALL advance and saturate: states ROW0 → ROW1 → PRIMED, then stay in PRIMED.
REQ-020 out_valid SHALL be 1 the cycle after an accepted pixel only when the row state at acceptance was PRIMED; otherwise it SHALL be 0.
REQ-021 in_valid=0 SHALL hold counters, state and buffers; out_valid SHALL drop to 0 the next cycle; data outputs hold.
REQ-022 in_sof with in_valid SHALL force column=0 and state=ROW0 for that pixel, even mid-line or mid-frame; the pixel is written normally.
REQ-023 After in_sof, out_valid SHALL first assert on row 2, col 0.
REQ-024 in_sof without in_valid SHALL be ignored.
REQ-025 Line buffer contents SHALL never influence out_valid, so stale data needs no clearing.

Reset
REQ-026 While rst_n=0: column=0, state=ROW0, out_valid=0, out_y1/out_y0/out_ym1=0, out_col=0.
REQ-027 Line buffer memories SHALL NOT be reset.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL behave as after in_sof.

Structure
REQ-029 Shared package SHALL hold DATA_W and IMG_WIDTH defaults, the column-index width constant, and the row-state enumerated type (ROW0, ROW1, PRIMED).
REQ-030 One sub-module, line_buffer, SHALL be used: single-port, read-before-write, IMG_WIDTH×DATA_W, no reset; instantiated twice.
REQ-031 All column-index arithmetic SHALL use the package width constant; IMG_WIDTH not a power of two SHALL be supported by compare-and-wrap.

Verification (IMG_WIDTH=4, DATA_W=8)
REQ-032 Frame test: in_sof, then pixels 0..15 back-to-back → out_valid first high after pixel 8; that output is (y1,y0,ym1,col)=(0,4,8,0); then (1,5,9,1) through (7,11,15,3).
REQ-033 Stall test: repeat REQ-032 with in_valid low for 3 cycles after pixel 9 → identical output sequence; out_valid=0 during the stall; outputs held.
REQ-034 Mid-frame sof: assert in_sof at pixel index 6 → out_valid stays 0 for the next 8 accepted pixels, then asserts at col 0.
REQ-035 Reset test: pull rst_n low asynchronously mid-row 2 → all outputs 0 immediately; after release and sof, the REQ-032 sequence repeats exactly.
REQ-036 Wrap test: feed 5 full rows of 0xFF → out_col follows 0,1,2,3,0,…; out_valid is high for 12 consecutive outputs; all data outputs read 0xFF.
